// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the stage-4 load/store unit.
package lsu_pkg;

  localparam int LANE_BYTES = 8;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} lsu_size_e;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} lsu_state_e;

  // Low address bits that must be zero for an access of this size to be aligned.
  function automatic logic [2:0] size_mask(input lsu_size_e size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [LANE_BYTES-1:0] byte_en(input lsu_size_e size, input logic [2:0] off);
    logic [15:0] lanes;
    lanes = ((16'd1 << (4'd1 << size)) - 16'd1) << off;
    return lanes[LANE_BYTES-1:0];
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Load-data extraction: shifts the addressed lanes down, masks to the access size
// and sign- or zero-extends to 64 bits.
module lsu_lane_align import lsu_pkg::*; (
  input  logic [63:0] mem_rdata,
  input  logic [2:0]  off,
  input  lsu_size_e   size,
  input  logic        sign_ext,
  output logic [63:0] load_data
);

  logic [63:0] raw;
  logic        fill;

  always_comb begin
    raw       = mem_rdata >> {off, 3'b000};
    fill      = 1'b0;
    load_data = raw;
    case (size)
      SZ_B: begin
        fill      = sign_ext & raw[7];
        load_data = {{56{fill}}, raw[7:0]};
      end
      SZ_H: begin
        fill      = sign_ext & raw[15];
        load_data = {{48{fill}}, raw[15:0]};
      end
      SZ_W: begin
        fill      = sign_ext & raw[31];
        load_data = {{32{fill}}, raw[31:0]};
      end
      default: load_data = raw;
    endcase
  end

endmodule

// File: rtl/stage4_load_store_unit.sv
// Stage-4 load/store initiator: one access at a time over a req/ack memory bus with byte lanes.
// Optional macro LSU_ALIGN_CHECK_EN: misaligned accesses error out without touching the bus.
module stage4_load_store_unit import lsu_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [63:0]           req_addr,
  input  logic [63:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [63:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [63:0]           mem_addr,
  output logic [63:0]           mem_wdata,
  output logic [LANE_BYTES-1:0] mem_byte_en,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [63:0]           mem_rdata,
  input  logic                  mem_ack
);

  localparam logic [1:0]       ST_IDLE  = IDLE;
  localparam logic [1:0]       ST_REQ   = REQ;
  localparam logic [1:0]       ST_RESP  = RESP;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  wr_q;
  logic                  sign_q;
  lsu_size_e             size_q;
  logic [2:0]            off_q;
  logic [60:0]           dw_q;
  logic [63:0]           wdata_q;
  logic [LANE_BYTES-1:0] be_q;
  logic [63:0]           rdata_q;
  logic                  err_q;

  lsu_size_e   req_sz;
  logic        accept;
  logic        misalign;
  logic [2:0]  req_off;
  logic [63:0] load_data;

  assign req_sz  = lsu_size_e'(req_size);
  assign accept  = req_valid && (state_q == ST_IDLE);
  // Without the check, misaligned addresses are silently aligned down within the dword.
  assign req_off = req_addr[2:0] & ~size_mask(req_sz);
`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = |(req_addr[2:0] & size_mask(req_sz));
`else
  assign misalign = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .mem_rdata (mem_rdata),
    .off       (off_q),
    .size      (size_q),
    .sign_ext  (sign_q),
    .load_data (load_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= SZ_B;
      off_q   <= '0;
      dw_q    <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          wr_q    <= req_write;
          sign_q  <= req_signed;
          size_q  <= req_sz;
          off_q   <= req_off;
          dw_q    <= req_addr[63:3];
          wdata_q <= req_wdata << {req_off, 3'b000};
          be_q    <= byte_en(req_sz, req_off);
          cnt_q   <= '0;
          rdata_q <= '0;
          err_q   <= misalign;
          state_q <= misalign ? ST_RESP : ST_REQ;
        end
        // ack is checked before the timeout so a last-cycle ack still completes cleanly
        ST_REQ: begin
          if (mem_ack) begin
            rdata_q <= wr_q ? 64'd0 : load_data;
            err_q   <= 1'b0;
            state_q <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: if (rsp_ready) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_error   = err_q;
  assign mem_addr    = {3'b000, dw_q};
  assign mem_wdata   = wdata_q;
  assign mem_byte_en = be_q;
  assign mem_read    = (state_q == ST_REQ) && !wr_q;
  assign mem_write   = (state_q == ST_REQ) && wr_q;

endmodule

// File: tb/tb_stage4_load_store_unit.sv
// Self-checking bench for stage4_load_store_unit: directed cases plus randomized accesses
// compared every cycle against a transaction-level model.
module tb_stage4_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [63:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_byte_en;
  logic        mem_read, mem_write, mem_ack;

  always #5 clk = ~clk;

  stage4_load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int tests = 0;
  int fails = 0;

  // Model state: what the bus and response ports must show right now
  bit          chk_en = 0;
  bit          in_req = 0, in_resp = 0;
  bit          exp_wr, exp_err;
  logic [63:0] exp_maddr, exp_wdata, exp_rdata;
  logic [7:0]  exp_be;

  int          strobe_total = 0;
  int          last_strobes;
  logic [63:0] last_maddr, last_wdata, last_rdata;
  logic [7:0]  last_be;
  bit          last_err;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_be(input int off, input int n);
    logic [7:0] be = '0;
    for (int i = 0; i < 8; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] d, input int off, input int n, input bit sgn);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = d[8*(off+i) +: 8];
    if (sgn && r[8*n-1])
      for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check64("req_ready", req_ready, !(in_req || in_resp));
      check64("mem_read", mem_read, in_req && !exp_wr);
      check64("mem_write", mem_write, in_req && exp_wr);
      check64("rsp_valid", rsp_valid, in_resp);
      if (mem_read || mem_write) strobe_total++;
      if (in_req) begin
        check64("mem_addr", mem_addr, exp_maddr);
        check64("mem_byte_en", mem_byte_en, exp_be);
        check64("mem_wdata", mem_wdata, exp_wdata);
        last_maddr = mem_addr;
        last_be    = mem_byte_en;
        last_wdata = mem_wdata;
      end
      if (in_resp) begin
        check64("rsp_rdata", rsp_rdata, exp_rdata);
        check64("rsp_error", rsp_error, exp_err);
        last_rdata = rsp_rdata;
        last_err   = rsp_error;
      end
    end
  end

  task automatic do_access(input bit wr, input logic [1:0] sz, input bit sgn,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] rdat, input int ack_dly, input int rsp_dly);
    int n, raw_off, off, s0;
    bit bad;
    n       = 1 << sz;
    raw_off = int'(addr[2:0]);
    off     = raw_off - (raw_off % n);
`ifdef LSU_ALIGN_CHECK_EN
    bad = (raw_off % n) != 0;
`else
    bad = 1'b0;
`endif
    @(posedge clk); #1;
    req_valid = 1; req_write = wr; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 0; req_write = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    s0 = strobe_total;
    exp_wr = wr; exp_maddr = addr >> 3; exp_be = model_be(off, n);
    exp_wdata = wdata << (8 * off);
    if (bad) begin
      in_resp = 1; exp_err = 1; exp_rdata = '0;
    end else begin
      in_req = 1;
      for (int k = 0; k < TO; k++) begin
        mem_ack   = (k == ack_dly);
        mem_rdata = (k == ack_dly) ? rdat : {$urandom, $urandom};
        rsp_ready = $urandom_range(0, 1);
        @(posedge clk); #1;
        if (k == ack_dly) begin
          in_req = 0; in_resp = 1; exp_err = 0;
          exp_rdata = wr ? 64'd0 : model_load(rdat, off, n, sgn);
          break;
        end
        if (k == TO - 1) begin
          in_req = 0; in_resp = 1; exp_err = 1; exp_rdata = '0;
        end
      end
    end
    // RESP: offer a competing request and stray acks; neither may disturb the response
    req_valid = 1;
    for (int d = 0; d <= rsp_dly; d++) begin
      rsp_ready = (d == rsp_dly);
      mem_ack   = $urandom_range(0, 1);
      mem_rdata = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_resp = 0; req_valid = 0; rsp_ready = 0; mem_ack = 0;
    last_strobes = strobe_total - s0;
  endtask

  initial begin
    reset_n = 0; req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0; rsp_ready = 0; mem_rdata = 0; mem_ack = 0;
    #12;
    check64("rst_req_ready", req_ready, 1);
    check64("rst_rsp_valid", rsp_valid, 0);
    check64("rst_strobes", {mem_read, mem_write}, 0);
    check64("rst_rsp_rdata", rsp_rdata, 0);
    check64("rst_mem_byte_en", mem_byte_en, 0);
    @(negedge clk); reset_n = 1; chk_en = 1;

    // 1: dword load, ack on the last allowed cycle
    do_access(0, 2'd3, 0, 64'h10, 64'h0, 64'h0123456789ABCDEF, 3, 0);
    check64("t1_maddr", last_maddr, 64'd2);
    check64("t1_be", last_be, 8'hFF);
    check64("t1_rdata", last_rdata, 64'h0123456789ABCDEF);
    check64("t1_err", last_err, 0);

    // 2: byte loads signed/unsigned
    do_access(0, 2'd0, 1, 64'h0B, 64'h0, 64'h0000_0000_8000_0000, 0, 1);
    check64("t2s_be", last_be, 8'h08);
    check64("t2s_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    do_access(0, 2'd0, 0, 64'h0B, 64'h0, 64'h0000_0000_8000_0000, 1, 0);
    check64("t2u_rdata", last_rdata, 64'h80);

    // 3: halfword store
    do_access(1, 2'd1, 0, 64'h06, 64'hBEEF, 64'h1234_5678_9ABC_DEF0, 2, 0);
    check64("t3_be", last_be, 8'hC0);
    check64("t3_wdata", last_wdata, 64'hBEEF_0000_0000_0000);
    check64("t3_rdata", last_rdata, 64'd0);
    check64("t3_strobes", last_strobes, 3);

    // 4: timeout
    do_access(0, 2'd3, 0, 64'h100, 64'h0, 64'h0, 99, 0);
    check64("t4_strobes", last_strobes, TO);
    check64("t4_err", last_err, 1);
    check64("t4_rdata", last_rdata, 64'd0);

    // 6: misaligned word store
    do_access(1, 2'd2, 0, 64'h02, 64'h1122_3344, 64'h0, 0, 0);
`ifdef LSU_ALIGN_CHECK_EN
    check64("t6_err", last_err, 1);
    check64("t6_strobes", last_strobes, 0);
`else
    check64("t6_err", last_err, 0);
    check64("t6_be", last_be, 8'h0F);
    check64("t6_maddr", last_maddr, 64'd0);
`endif

    // 5: response held through a 5-cycle stall, then reset lands mid-REQ
    do_access(0, 2'd3, 0, 64'h40, 64'h0, 64'hCAFE_F00D_DEAD_BEEF, 1, 5);
    @(posedge clk); #1;
    req_valid = 1; req_write = 0; req_size = 2'd3; req_signed = 0;
    req_addr = 64'h88; req_wdata = 64'h5555;
    @(posedge clk); #1;
    req_valid = 0; in_req = 1; exp_wr = 0; exp_maddr = 64'h11; exp_be = 8'hFF; exp_wdata = 64'h5555;
    @(posedge clk); #2;
    reset_n = 0; in_req = 0;
    #1;
    check64("t5_mem_read", mem_read, 0);
    check64("t5_req_ready", req_ready, 1);
    check64("t5_rsp_valid", rsp_valid, 0);
    check64("t5_mem_addr", mem_addr, 0);
    check64("t5_mem_wdata", mem_wdata, 0);
    check64("t5_mem_byte_en", mem_byte_en, 0);
    @(negedge clk); #2;
    reset_n = 1;

    // randomized traffic
    for (int t = 0; t < 200; t++) begin
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, TO + 1), $urandom_range(0, 3));
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
